laser_job_ctrl: RTL and testbench

Job controller that shares one `LASER` coverage core between two requesters. A granted requester streams a 40-point frame into a local buffer through a valid/ready handshake. The controller then holds the core in reset and replays the frame into it on the exact 40 sampling cycles the core expects. It waits for the core's `DONE`, then returns the two circle centres to the requester with an ID, plus an error flag if the core times out.

---
 rtl/laser_pkg.sv | 27 ++
 rtl/laser_rr_arb2.sv | 30 +++
 rtl/laser_job_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_laser_job_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types for the LASER job controller: frame size, coordinate type,
// controller states and the result record handed back to a requester.
package laser_pkg;

  localparam int NPTS = 40;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RSTC,
    FEED,
    RUN,
    RESP
  } state_t;

  typedef struct packed {
    coord_t c1x;
    coord_t c1y;
    coord_t c2x;
    coord_t c2y;
    logic   err;
    logic   id;
  } laser_res_t;

endpackage

// File: rtl/laser_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant and a registered
// pointer that moves to favour the loser whenever a grant is taken.
module laser_rr_arb2 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic fav1_reg;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!fav1_reg || !req[1])) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fav1_reg <= 1'b0;
    end else if (take && (|req)) begin
      fav1_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/laser_job_ctrl.sv
// Shares one LASER core between two requesters: buffers a 40-point frame,
// resets and replays it into the core, then returns centres or a timeout.
module laser_job_ctrl
  import laser_pkg::*;
#(
  parameter int RST_HOLD = 2,
  parameter int TIMEOUT  = 32767
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] REQ,
  output logic [1:0] GNT,
  input  logic       PT_VALID,
  output logic       PT_READY,
  input  logic [3:0] PT_X,
  input  logic [3:0] PT_Y,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic       RES_ID,
  output logic       RES_ERR,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic       CORE_RST,
  output logic [3:0] CORE_X,
  output logic [3:0] CORE_Y,
  input  logic       CORE_DONE,
  input  logic [3:0] CORE_C1X,
  input  logic [3:0] CORE_C1Y,
  input  logic [3:0] CORE_C2X,
  input  logic [3:0] CORE_C2Y,
  output logic       BUSY
);

  localparam logic [5:0]  LAST_IDX = 6'(NPTS - 1);
  localparam logic [5:0]  FEED_END = 6'(NPTS);
  localparam logic [5:0]  HOLD_END = 6'(RST_HOLD - 1);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  state_t     state_reg, state_next;
  logic [5:0] idx_reg, idx_next;
  logic [15:0] wd_reg, wd_next, wd_inc;
  logic [1:0] gnt_reg, gnt_next;
  logic       id_reg, id_next;
  laser_res_t res_reg, res_next;
  logic [7:0] core_pt_reg, core_pt_next;
  logic [7:0] frame_mem [NPTS];
  logic [1:0] arb_gnt;
  logic       arb_take, accept, last_accept;

  assign arb_take = (state_reg == IDLE);

  laser_rr_arb2 u_arb (
    .CLK  (CLK),
    .RST_N(RST_N),
    .req  (REQ),
    .take (arb_take),
    .gnt  (arb_gnt)
  );

  assign accept      = (state_reg == LOAD) && PT_VALID;
  assign last_accept = accept && (idx_reg == LAST_IDX);
  assign wd_inc      = wd_reg + 16'd1;

  always_ff @(posedge CLK) begin
    if (accept) begin
      frame_mem[idx_reg] <= {PT_X, PT_Y};
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    wd_next      = wd_reg;
    gnt_next     = gnt_reg;
    id_next      = id_reg;
    res_next     = res_reg;
    core_pt_next = 8'h00;
    case (state_reg)
      IDLE: begin
        if (|REQ) begin
          gnt_next   = arb_gnt;
          id_next    = arb_gnt[1];
          idx_next   = 6'd0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // The 40th accept wins over a request drop in the same cycle.
        if (last_accept) begin
          gnt_next   = 2'b00;
          idx_next   = 6'd0;
          state_next = RSTC;
        end else if (!(|(REQ & gnt_reg))) begin
          gnt_next   = 2'b00;
          state_next = IDLE;
        end else if (accept) begin
          idx_next = idx_reg + 6'd1;
        end
      end
      RSTC: begin
        if (idx_reg == HOLD_END) begin
          idx_next   = 6'd0;
          state_next = FEED;
        end else begin
          idx_next = idx_reg + 6'd1;
        end
      end
      FEED: begin
        // Registered read: point f is presented during FEED cycle f+1.
        if (idx_reg == FEED_END) begin
          idx_next   = 6'd0;
          wd_next    = 16'd0;
          state_next = RUN;
        end else begin
          core_pt_next = frame_mem[idx_reg];
          idx_next     = idx_reg + 6'd1;
        end
      end
      RUN: begin
        wd_next = wd_inc;
        if (CORE_DONE) begin
          res_next.c1x = CORE_C1X;
          res_next.c1y = CORE_C1Y;
          res_next.c2x = CORE_C2X;
          res_next.c2y = CORE_C2Y;
          res_next.err = 1'b0;
          res_next.id  = id_reg;
          state_next   = RESP;
        end else if (wd_inc == WD_LIMIT) begin
          res_next     = '0;
          res_next.err = 1'b1;
          res_next.id  = id_reg;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (RES_READY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      idx_reg     <= 6'd0;
      wd_reg      <= 16'd0;
      gnt_reg     <= 2'b00;
      id_reg      <= 1'b0;
      res_reg     <= '0;
      core_pt_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      wd_reg      <= wd_next;
      gnt_reg     <= gnt_next;
      id_reg      <= id_next;
      res_reg     <= res_next;
      core_pt_reg <= core_pt_next;
    end
  end

  assign GNT       = gnt_reg;
  assign PT_READY  = (state_reg == LOAD);
  assign RES_VALID = (state_reg == RESP);
  assign RES_ID    = res_reg.id;
  assign RES_ERR   = res_reg.err;
  assign RES_C1X   = res_reg.c1x;
  assign RES_C1Y   = res_reg.c1y;
  assign RES_C2X   = res_reg.c2x;
  assign RES_C2Y   = res_reg.c2y;
  assign CORE_RST  = !((state_reg == FEED) || (state_reg == RUN));
  assign CORE_X    = core_pt_reg[7:4];
  assign CORE_Y    = core_pt_reg[3:0];
  assign BUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_laser_job_ctrl.sv
// Directed bench for laser_job_ctrl with a behavioural LASER core model that
// records the fed points and raises DONE a fixed time into RUN (or never).
module tb_laser_job_ctrl;

  localparam int RST_HOLD = 2;
  localparam int TIMEOUT  = 100;
  localparam logic [31:0] RESET_VEC = 32'h0000_0200;

  logic       CLK, RST_N;
  logic [1:0] REQ, GNT;
  logic       PT_VALID, PT_READY;
  logic [3:0] PT_X, PT_Y;
  logic       RES_VALID, RES_READY, RES_ID, RES_ERR;
  logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic       CORE_RST, CORE_DONE, BUSY;
  logic [3:0] CORE_X, CORE_Y;
  logic [3:0] CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] pts [40];
  logic [7:0] samp [40];
  int   mcnt = 0;
  logic done_en;

  laser_job_ctrl #(.RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .GNT(GNT),
    .PT_VALID(PT_VALID), .PT_READY(PT_READY), .PT_X(PT_X), .PT_Y(PT_Y),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_ID(RES_ID), .RES_ERR(RES_ERR),
    .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y),
    .CORE_RST(CORE_RST), .CORE_X(CORE_X), .CORE_Y(CORE_Y), .CORE_DONE(CORE_DONE),
    .CORE_C1X(CORE_C1X), .CORE_C1Y(CORE_C1Y), .CORE_C2X(CORE_C2X), .CORE_C2Y(CORE_C2Y),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Core model: mcnt is the cycle index since CORE_RST fell (FEED cycle f).
  always @(posedge CLK) begin
    if (CORE_RST) begin
      mcnt <= 0;
    end else begin
      if (mcnt >= 1 && mcnt <= 40) samp[mcnt-1] <= {CORE_X, CORE_Y};
      if (mcnt < 1000) mcnt <= mcnt + 1;
    end
  end
  assign CORE_DONE = (mcnt <= 1) || (done_en && mcnt >= 44);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] outs_vec();
    return {GNT, PT_READY, RES_VALID, RES_ID, RES_ERR, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y,
            CORE_RST, CORE_X, CORE_Y, BUSY};
  endfunction

  function automatic logic [22:0] res_vec();
    return {RES_VALID, RES_ID, RES_ERR, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, CORE_RST, BUSY, GNT};
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < 40; k++) begin
      case (mode)
        0:       pts[k] = 8'h55;
        1:       pts[k] = {4'(k), 4'(k * 7 + 3)};
        default: pts[k] = {4'(k * 3 + 1), 4'(k / 3)};
      endcase
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    check("reset_vals", outs_vec(), RESET_VEC);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic wait_grant(input logic [1:0] exp_gnt);
    int n = 0;
    while (GNT == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    check("grant", 32'(GNT), 32'(exp_gnt));
    check("grant_latency", 32'(n), 32'd1);
    check("grant_ready", 32'(PT_READY), 32'd1);
  endtask

  task automatic stream(input bit stall, input bit drop_last, input int npts,
                        input logic [1:0] exp_gnt, output int cyc);
    int  k = 0;
    bit  bad = 0;
    logic acc;
    cyc = 0;
    while (k < npts && cyc < 200) begin
      PT_VALID = stall ? cyc[0] : 1'b1;
      PT_X = pts[k][7:4];
      PT_Y = pts[k][3:0];
      if (drop_last && k == 39 && PT_VALID) REQ = 2'b00;
      if (GNT !== exp_gnt || PT_READY !== 1'b1) bad = 1;
      acc = PT_VALID && PT_READY;
      tick();
      if (acc) k++;
      cyc++;
    end
    PT_VALID = 1'b0;
    check("load_gnt_held", 32'(bad), 32'd0);
  endtask

  task automatic run_job(input logic [1:0] req_v, input logic [1:0] exp_gnt, input bit stall,
                         input bit drop_last, input bit to, input int hold, input bit keep_req,
                         input logic [15:0] core_res);
    int cyc;
    int n;
    int m;
    logic [22:0] exp_r;
    {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y} = core_res;
    done_en = !to;
    REQ = req_v;
    wait_grant(exp_gnt);
    stream(stall, drop_last, 40, exp_gnt, cyc);
    check("load_cycles", 32'(cyc), stall ? 32'd80 : 32'd40);
    check("load_end", 32'({GNT, PT_READY, CORE_RST}), 32'b0001);
    n = 1;
    while (CORE_RST && n < 20) begin
      tick();
      n++;
    end
    check("rst_fall", 32'(n), 32'(RST_HOLD + 1));
    m = 0;
    while (!RES_VALID && m < 400) begin
      tick();
      m++;
    end
    check("res_latency", 32'(m), to ? 32'(41 + TIMEOUT) : 32'd45);
    exp_r = {1'b1, exp_gnt[1], to, (to ? 16'h0000 : core_res), 1'b1, 1'b1, 2'b00};
    check("result", 32'(res_vec()), 32'(exp_r));
    RES_READY = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("res_hold", 32'(res_vec()), 32'(exp_r));
    end
    if (!keep_req) REQ = 2'b00;
    RES_READY = 1'b1;
    tick();
    check("res_drop", 32'({RES_VALID, BUSY}), 32'b00);
    for (int k = 0; k < 40; k++) check("feed_order", 32'(samp[k]), 32'(pts[k]));
  endtask

  initial begin
    int cyc;
    int n;
    bit seen;
    RST_N = 1'b0; REQ = 2'b00; PT_VALID = 1'b0; PT_X = 4'h0; PT_Y = 4'h0;
    RES_READY = 1'b1; done_en = 1'b1;
    {CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y} = 16'h0000;
    #3;
    check("reset_vals", outs_vec(), RESET_VEC);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // Single job, all points (5,5), core returns (5,5,12,12).
    fill(0);
    run_job(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'h55CC);

    // Fresh pointer, then round-robin with REQ=11 held; middle job stalls.
    do_reset();
    fill(1);
    run_job(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'hA1B2);
    fill(2);
    run_job(2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 0, 1'b1, 16'h1234);
    fill(1);
    run_job(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'hFEDC);

    // Timeout with 50 cycles of result backpressure.
    fill(2);
    run_job(2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 50, 1'b0, 16'hABCD);

    // Abort after 17 accepts, then requester 1 dropping REQ on its 40th accept.
    fill(1);
    REQ = 2'b01;
    wait_grant(2'b01);
    stream(1'b0, 1'b0, 17, 2'b01, cyc);
    REQ = 2'b00;
    PT_VALID = 1'b1;
    tick();
    PT_VALID = 1'b0;
    check("abort", 32'({GNT, PT_READY, BUSY}), 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (RES_VALID) seen = 1;
      tick();
    end
    check("abort_no_result", 32'(seen), 32'd0);
    fill(2);
    run_job(2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 0, 1'b0, 16'h39E1);

    // Reset pulsed during FEED.
    fill(0);
    REQ = 2'b10;
    wait_grant(2'b10);
    stream(1'b0, 1'b0, 40, 2'b10, cyc);
    REQ = 2'b00;
    n = 0;
    while (CORE_RST && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) tick();
    #2;
    RST_N = 1'b0;
    #1;
    check("reset_in_feed", outs_vec(), RESET_VEC);
    @(negedge CLK);
    RST_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (RES_VALID || BUSY) seen = 1;
    end
    check("reset_job_lost", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
